// File: rtl/event_tagger_pkg.sv
// Shared record layout helpers and record-type constants for the event tagger
// family. The RTL, benches and the host-side decoder all use these, so the
// field positions are defined in one place.
package event_tagger_pkg;

   // Kinds of record a host can see on the stream.
   typedef enum logic [1:0] {
      REC_EMPTY             = 2'd0,  // W=0, no channels: never produced
      REC_STROBE            = 2'd1,  // channel bits set, W=0
      REC_WRAP              = 2'd2,  // pure wrap marker {1, 0, 0}
      REC_STROBE_AFTER_WRAP = 2'd3   // channel bits set, W=1
   } rec_kind_e;

   // Total record width: wrap flag + channel bits + timestamp.
   function automatic int record_w(input int n_ch, input int ts_w);
      return 1 + n_ch + ts_w;
   endfunction

   // Position of the wrap flag (MSB of the record).
   function automatic int wrap_bit(input int n_ch, input int ts_w);
      return n_ch + ts_w;
   endfunction

   // Channel field bounds.
   function automatic int chan_lsb(input int ts_w);
      return ts_w;
   endfunction

   function automatic int chan_msb(input int n_ch, input int ts_w);
      return ts_w + n_ch - 1;
   endfunction

   // Timestamp field bounds.
   function automatic int ts_lsb();
      return 0;
   endfunction

   function automatic int ts_msb(input int ts_w);
      return ts_w - 1;
   endfunction

   // Classify a record from its wrap flag and "any channel bit set".
   function automatic rec_kind_e classify(input logic w, input logic any_ch);
      rec_kind_e k;
      case ({w, any_ch})
         2'b01:   k = REC_STROBE;
         2'b10:   k = REC_WRAP;
         2'b11:   k = REC_STROBE_AFTER_WRAP;
         default: k = REC_EMPTY;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// N-wide synchroniser chain for asynchronous detector strobes followed by a
// single history flop, giving a one-cycle rising-edge pulse per channel.
// SYNC_STAGES must be at least 2 for metastability protection.
module strobe_sync_edge #(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] i_strobe,
   output logic [N-1:0] o_edge
);

   logic [N-1:0] r_sync [SYNC_STAGES];
   logic [N-1:0] r_hist;

   // Shift raw strobes through the synchroniser, then keep one history sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
         r_hist <= '0;
      end else begin
         r_sync[0] <= i_strobe;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/event_tagger_stream.sv
// Timestamps rising edges on N strobe channels against a free-running counter,
// folds counter wraps into the record stream and presents records on a
// valid/ready interface with a saturating lost-record counter.
module event_tagger_stream
   import event_tagger_pkg::*;
#(
   parameter int N_CHANNELS  = 4,
   parameter int TS_W        = 42,
   parameter int SYNC_STAGES = 2,
   parameter int LOST_W      = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_CHANNELS-1:0]      strobe_channels,
   input  logic [N_CHANNELS-1:0]      channel_mask,
   input  logic                       reset_counter,
   input  logic                       capture_operate,
   input  logic                       counter_operate,
   output logic [N_CHANNELS+TS_W:0]   data,
   output logic                       valid,
   input  logic                       ready,
   output logic [LOST_W-1:0]          lost_count
);

   localparam int C_W_BIT  = wrap_bit(N_CHANNELS, TS_W);
   localparam int C_CH_LSB = chan_lsb(TS_W);
   localparam int C_CH_MSB = chan_msb(N_CHANNELS, TS_W);
   localparam logic [TS_W-1:0] C_TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

   logic [N_CHANNELS-1:0]    w_edge;
   logic [N_CHANNELS-1:0]    w_hits;
   logic                     w_wrap_evt;
   logic                     w_slot_free;
   logic                     w_load_hit;
   logic                     w_load_wrap;
   logic                     w_drop_hit;
   logic                     w_drop_wrap;
   logic [LOST_W:0]          w_lost_sum;

   logic [TS_W-1:0]          r_count;
   logic                     r_wrap_pending;
   logic                     r_valid;
   logic [N_CHANNELS+TS_W:0] r_data;
   logic [LOST_W-1:0]        r_lost;

   strobe_sync_edge #(
      .N           (N_CHANNELS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_strobe (strobe_channels),
      .o_edge   (w_edge)
   );

   assign w_hits      = capture_operate ? (w_edge & channel_mask) : '0;
   assign w_wrap_evt  = counter_operate & ~reset_counter & (&r_count);
   assign w_slot_free = ~r_valid | ready;
   assign w_load_hit  = w_slot_free & (|w_hits);
   assign w_load_wrap = w_slot_free & ~(|w_hits) & r_wrap_pending;
   assign w_drop_hit  = ~w_slot_free & (|w_hits);
   // A second wrap while the first is still undelivered cannot be represented.
   assign w_drop_wrap = ~w_slot_free & w_wrap_evt & r_wrap_pending;
   // Both losses in one cycle count as two dropped records.
   assign w_lost_sum  = {1'b0, r_lost} + {{LOST_W{1'b0}}, w_drop_hit}
                                       + {{LOST_W{1'b0}}, w_drop_wrap};

   // Free-running timestamp counter; reset_counter has priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (reset_counter) begin
         r_count <= '0;
      end else if (counter_operate) begin
         r_count <= r_count + C_TS_ONE;
      end
   end

   // Wrap bookkeeping: a new wrap wins over the clear caused by a load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wrap_pending <= 1'b0;
      end else if (reset_counter) begin
         r_wrap_pending <= 1'b0;
      end else if (w_wrap_evt) begin
         r_wrap_pending <= 1'b1;
      end else if (w_load_hit || w_load_wrap) begin
         r_wrap_pending <= 1'b0;
      end
   end

   // Saturating count of records that found the output slot occupied.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lost <= '0;
      end else if (reset_counter) begin
         r_lost <= '0;
      end else if (w_lost_sum[LOST_W]) begin
         r_lost <= '1;
      end else begin
         r_lost <= w_lost_sum[LOST_W-1:0];
      end
   end

   // Output slot: strobe records first, then pending wrap markers; held under backpressure.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_load_hit) begin
         r_valid                   <= 1'b1;
         r_data[C_W_BIT]           <= r_wrap_pending;
         r_data[C_CH_MSB:C_CH_LSB] <= w_hits;
         r_data[TS_W-1:0]          <= r_count;
      end else if (w_load_wrap) begin
         r_valid                   <= 1'b1;
         r_data[C_W_BIT]           <= 1'b1;
         r_data[C_CH_MSB:C_CH_LSB] <= '0;
         r_data[TS_W-1:0]          <= '0;
      end else if (w_slot_free) begin
         r_valid <= 1'b0;
      end
   end

   assign data       = r_data;
   assign valid      = r_valid;
   assign lost_count = r_lost;

endmodule

// File: tb/tb_event_tagger_stream.sv
// Bench for event_tagger_stream: directed scenarios followed by randomized
// traffic, checked every cycle against an absolute-time reference model and a
// host-side decoder that rebuilds absolute time from the record stream.
module tb_event_tagger_stream;
   import event_tagger_pkg::*;

   localparam int N        = 4;
   localparam int TSW      = 8;
   localparam int SS       = 2;
   localparam int LW       = 4;
   localparam int RW       = record_w(N, TSW);
   localparam int WB       = wrap_bit(N, TSW);
   localparam int TS_MOD   = 1 << TSW;
   localparam int LOST_MAX = (1 << LW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [N-1:0]  strobe_channels = '0;
   logic [N-1:0]  channel_mask = '1;
   logic          reset_counter = 1'b0;
   logic          capture_operate = 1'b0;
   logic          counter_operate = 1'b0;
   logic          ready = 1'b0;
   logic [RW-1:0] data;
   logic          valid;
   logic [LW-1:0] lost_count;

   event_tagger_stream #(
      .N_CHANNELS (N), .TS_W (TSW), .SYNC_STAGES (SS), .LOST_W (LW)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .strobe_channels (strobe_channels),
      .channel_mask    (channel_mask),
      .reset_counter   (reset_counter),
      .capture_operate (capture_operate),
      .counter_operate (counter_operate),
      .data            (data),
      .valid           (valid),
      .ready           (ready),
      .lost_count      (lost_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: absolute elapsed counter ticks; the hardware count is its residue.
   longint        m_abs;
   bit            m_wp;
   bit            m_valid;
   logic [RW-1:0] m_data;
   int            m_lost;
   bit [N-1:0]    m_samp[$];   // strobe levels at the last three clock edges, oldest first
   longint        m_slot_abs;  // absolute time of the strobe record in the slot

   // Host-side decoder state
   logic [RW-1:0] acc_q[$];
   longint        host_base = 0;
   bit            host_on = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_abs      = 0;
      m_wp       = 1'b0;
      m_valid    = 1'b0;
      m_data     = '0;
      m_lost     = 0;
      m_samp     = '{4'b0, 4'b0, 4'b0};
      m_slot_abs = 0;
   endtask

   // One clock: record the handshake, advance the model, then compare outputs.
   task automatic step();
      bit [N-1:0]    edg;
      bit [N-1:0]    hits;
      bit            wrap_evt;
      bit            free;
      bit            loaded;
      int            losses;
      logic [RW-1:0] d;
      if (valid === 1'b1 && ready) begin
         d = data;
         acc_q.push_back(d);
         if (d[WB]) host_base += TS_MOD;
         if (host_on && d[WB-1:TSW] != '0)
            check("host_abs_time", 64'(host_base + longint'(d[TSW-1:0])), 64'(m_slot_abs));
      end
      // A channel hits when it was high two edges ago and low three edges ago.
      edg      = m_samp[1] & ~m_samp[0];
      hits     = capture_operate ? (edg & channel_mask) : '0;
      wrap_evt = counter_operate && !reset_counter && ((m_abs % TS_MOD) == TS_MOD - 1);
      free     = !m_valid || ready;
      losses   = 0;
      loaded   = 1'b0;
      if (free && hits != '0) begin
         m_data     = {m_wp, hits, TSW'(m_abs % TS_MOD)};
         m_valid    = 1'b1;
         m_slot_abs = m_abs;
         loaded     = 1'b1;
      end else if (free && m_wp) begin
         m_data  = {1'b1, {N{1'b0}}, {TSW{1'b0}}};
         m_valid = 1'b1;
         loaded  = 1'b1;
      end else if (free) begin
         m_valid = 1'b0;
      end else begin
         if (hits != '0) losses++;
         if (wrap_evt && m_wp) losses++;
      end
      if (reset_counter) begin
         m_wp   = 1'b0;
         m_lost = 0;
         m_abs  = 0;
      end else begin
         if (wrap_evt) m_wp = 1'b1;
         else if (loaded) m_wp = 1'b0;
         m_lost = (m_lost + losses > LOST_MAX) ? LOST_MAX : m_lost + losses;
         if (counter_operate) m_abs++;
      end
      m_samp.push_back(strobe_channels);
      void'(m_samp.pop_front());
      @(posedge clk);
      #1;
      check("valid", 64'(valid), 64'(m_valid));
      check("data", 64'(data), 64'(m_data));
      check("lost_count", 64'(lost_count), 64'(m_lost));
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rp;
      logic [RW-1:0] exp_held;
      model_reset();
      // Asynchronous reset with no clock edge yet
      #1 reset_n = 1'b0;
      #1;
      check("reset_valid", 64'(valid), 64'(0));
      check("reset_data", 64'(data), 64'(0));
      check("reset_lost", 64'(lost_count), 64'(0));
      #6 reset_n = 1'b1;

      // Single edge on ch0 with count running from 0
      capture_operate = 1'b1;
      counter_operate = 1'b1;
      ready           = 1'b1;
      channel_mask    = 4'b1111;
      reset_counter   = 1'b1;
      step();
      reset_counter = 1'b0;
      host_base = 0;
      host_on   = 1'b1;
      acc_q.delete();
      strobe_channels = 4'b0001;
      repeat (10) step();
      strobe_channels = 4'b0000;
      repeat (5) step();
      check("single_count", 64'(acc_q.size()), 64'(1));
      check("single_rec", 64'((acc_q.size() > 0) ? acc_q[0] : '0), 64'({1'b0, 4'b0001, 8'd2}));

      // Coincident edges on ch1 and ch3
      acc_q.delete();
      strobe_channels = 4'b1010;
      repeat (6) step();
      strobe_channels = 4'b0000;
      repeat (4) step();
      check("coinc_count", 64'(acc_q.size()), 64'(1));
      check("coinc_chan", 64'((acc_q.size() > 0) ? acc_q[0][WB:TSW] : '0), 64'(5'b01010));

      // Wrap with quiet channels: one pure wrap record, then nothing
      acc_q.delete();
      for (int i = 0; i < 400 && m_abs < TS_MOD + 20; i++) step();
      check("wrap_count", 64'(acc_q.size()), 64'(1));
      check("wrap_rec", 64'((acc_q.size() > 0) ? acc_q[0] : '0), 64'({1'b1, 4'b0000, 8'h00}));
      check("wrap_kind", 64'((acc_q.size() > 0) ? classify(acc_q[0][WB], |acc_q[0][WB-1:TSW]) : REC_EMPTY),
            64'(REC_WRAP));

      // Edge detected at count=255: strobe record keeps W=0, wrap follows
      acc_q.delete();
      for (int i = 0; i < 400 && (m_abs % TS_MOD) != TS_MOD - 3; i++) step();
      strobe_channels = 4'b0001;
      repeat (6) step();
      strobe_channels = 4'b0000;
      repeat (4) step();
      check("wrapcoinc_count", 64'(acc_q.size()), 64'(2));
      check("wrapcoinc_rec0", 64'((acc_q.size() > 0) ? acc_q[0] : '0), 64'({1'b0, 4'b0001, 8'hFF}));
      check("wrapcoinc_rec1", 64'((acc_q.size() > 1) ? acc_q[1] : '0), 64'({1'b1, 4'b0000, 8'h00}));
      host_on = 1'b0;

      // Backpressure: held record, three dropped ch2 edges
      counter_operate = 1'b0;
      ready           = 1'b0;
      strobe_channels = 4'b0001;
      repeat (5) step();
      strobe_channels = 4'b0000;
      exp_held = {1'b0, 4'b0001, TSW'(m_abs % TS_MOD)};
      for (int k = 0; k < 3; k++) begin
         strobe_channels = 4'b0100;
         repeat (2) step();
         strobe_channels = 4'b0000;
         repeat (2) step();
      end
      repeat (3) step();
      check("bp_data_held", 64'(data), 64'(exp_held));
      check("bp_valid_held", 64'(valid), 64'(1));
      check("bp_lost", 64'(lost_count), 64'(3));
      acc_q.delete();
      ready = 1'b1;
      step();
      check("bp_accepted", 64'(acc_q.size()), 64'(1));
      check("bp_valid_drop", 64'(valid), 64'(0));
      reset_counter = 1'b1;
      step();
      reset_counter = 1'b0;
      check("bp_lost_clear", 64'(lost_count), 64'(0));

      // Randomized traffic with varying backpressure
      for (int i = 0; i < 1500; i++) begin
         rp = ((i / 250) % 3 == 0) ? 95 : (((i / 250) % 3 == 1) ? 50 : 10);
         ready           = ($urandom_range(99) < rp);
         capture_operate = ($urandom_range(9) != 0);
         counter_operate = ($urandom_range(19) != 0);
         reset_counter   = ($urandom_range(199) == 0);
         if ($urandom_range(49) == 0) channel_mask = N'($urandom);
         strobe_channels = strobe_channels ^ (N'($urandom) & N'($urandom));
         step();
      end

      // Reset mid-operation with a held record and a pending wrap
      reset_counter   = 1'b0;
      capture_operate = 1'b1;
      counter_operate = 1'b1;
      channel_mask    = 4'b1111;
      strobe_channels = 4'b0000;
      repeat (4) step();
      ready = 1'b0;
      strobe_channels = 4'b0001;
      repeat (5) step();
      strobe_channels = 4'b0000;
      for (int i = 0; i < 400 && !m_wp; i++) step();
      check("prereset_valid", 64'(valid), 64'(1));
      check("prereset_wp", 64'(m_wp), 64'(1));
      #3 reset_n = 1'b0;
      #1;
      check("async_valid", 64'(valid), 64'(0));
      check("async_data", 64'(data), 64'(0));
      check("async_lost", 64'(lost_count), 64'(0));
      model_reset();
      #1 reset_n = 1'b1;
      ready = 1'b1;
      acc_q.delete();
      repeat (20) step();
      check("postreset_no_record", 64'(acc_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
